pri_encoder_rr_reg: RTL
=======================

// Module: pri_encoder_rr_reg
// PURPOSE
//  Parametrised, registered priority encoder with selectable fixed-priority or round-robin search.
//  Converts a WIDTH-bit request vector into a binary index plus one-hot grant.
//  Result is held in a one-entry output register with a valid/ready handshake.
//  Sits between request collectors (interrupt and arbitration sources) and a downstream consumer.
//  Successor to the 16:4 combinational encoder: adds any width, round-robin fairness, backpressure and latency 1.
// PARAMETERS
//  WIDTH    16                 number of request inputs, >= 2
//  OUT_W    $clog2(WIDTH)      width of binary_out, >= 1
// PORTS
//  clk         in   1       rising-edge clock
//  reset_n     in   1       asynchronous active-low reset
//  enable      in   1       capture permitted when 1
//  rr_mode     in   1       0 = fixed priority (lowest index wins), 1 = round-robin
//  req_in      in   WIDTH   request vector, bit i = request i
//  out_ready   in   1       consumer accepts result this cycle
//  out_valid   out  1       binary_out/onehot_out hold a valid grant
//  binary_out  out  OUT_W   index of granted request
//  onehot_out  out  WIDTH   one-hot of granted request
//  rr_ptr      out  OUT_W   current round-robin start index (debug/observe)
// BEHAVIOUR
//  Reset (async on reset_n=0, any time): out_valid=0, binary_out=0, onehot_out=0, rr_ptr=0.
//   Any in-flight result is discarded. Release is synchronous to clk; first capture is possible on the first edge after release.
//  Capture condition at a clk edge: cap = enable & |req_in & (!out_valid | out_ready).
//  Fixed mode: winner = lowest set index of req_in (bit0 highest priority).
//  RR mode: winner = first set index scanning rr_ptr, rr_ptr+1, ..., WIDTH-1, 0, ..., rr_ptr-1 (modulo WIDTH wrap).
//  On cap: binary_out<=winner, onehot_out<=1<<winner, out_valid<=1 (latency 1 cycle).
//   In rr_mode only: rr_ptr <= (winner==WIDTH-1) ? 0 : winner+1. Fixed mode leaves rr_ptr unchanged.
//  Handshake: transfer happens when out_valid & out_ready.
//   Transfer with no cap in the same cycle: out_valid<=0. binary_out/onehot_out keep their last value.
//   Transfer plus cap in the same cycle: the new result replaces the old one. out_valid stays 1, giving back-to-back throughput of 1/cycle.
//   out_valid & !out_ready: outputs frozen, req_in ignored, rr_ptr frozen.
//  No request (req_in==0) or enable=0: no capture, and no state change except the handshake clear.
//  rr_mode is sampled only at capture. Switching modes neither resets rr_ptr nor alters a held result.
//  binary_out==0 with out_valid=1 is a legal grant of request 0. Only out_valid marks "no grant".
//  Non-power-of-2 WIDTH: indices >= WIDTH are never produced. rr_ptr wrap uses WIDTH, not 2**OUT_W.
//  req_in is not latched. Requesters keep a request asserted until they see their onehot_out bit transferred.
//  Search is combinational over WIDTH bits (double-vector rotate or masked two-pass). It must close timing at WIDTH=64.
// TESTING (WIDTH=16 unless noted)
//  1. Reset mid-operation: hold out_valid=1 with out_ready=0, then pulse reset_n=0.
//     -> out_valid, binary_out and rr_ptr drop to 0 immediately, with no clk edge.
//  2. Fixed mode, enable=1, out_ready=1:
//     req_in=16'h8010 -> next cycle binary_out=4, onehot_out=16'h0010.
//     req_in=16'h8000 -> 15. req_in=16'h0001 -> 0 with out_valid=1.
//  3. RR mode, req_in=16'h8011 held, out_ready=1: grants 0,4,15,0,4.
//     rr_ptr sequence 1,5,0,1,5 (wrap at 15 -> 0).
//  4. Backpressure: grant 4 valid with out_ready=0 for 3 cycles while req_in changes to 16'h0002.
//     -> binary_out stays 4. On out_ready=1 the next cycle shows 1.
//  5. Idle: req_in=0 or enable=0 with out_ready=1 -> out_valid falls after the transfer and stays 0. rr_ptr unchanged.
//  6. WIDTH=5, OUT_W=3, rr_mode=1, req_in=5'b10001 -> grants 0,4,0 with rr_ptr 1,0,1. No index above 4 is ever produced.

Source files
------------

// File: rtl/pri_encoder_rr_reg.sv
// pri_encoder_rr_reg: registered fixed-priority / round-robin priority encoder
// with a one-entry valid/ready output stage.
module pri_encoder_rr_reg #(
  parameter int WIDTH = 16,
  parameter int OUT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             rr_mode,
  input  logic [WIDTH-1:0] req_in,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [OUT_W-1:0] binary_out,
  output logic [WIDTH-1:0] onehot_out,
  output logic [OUT_W-1:0] rr_ptr
);
  logic             vld_q, vld_d, cap, hi_any;
  logic [OUT_W-1:0] bin_q, bin_d, ptr_q, ptr_d, winner;
  logic [WIDTH-1:0] oh_q, oh_d, rr_mask, req_hi;
  function automatic logic [OUT_W-1:0] lowest(input logic [WIDTH-1:0] v);
    lowest = '0;
    for (int i = WIDTH - 1; i >= 0; i--)
      if (v[i]) lowest = OUT_W'(i);
  endfunction
  // Masked two-pass search: requests at or above the pointer first, else wrap to all.
  always_comb begin
    rr_mask = ~((WIDTH'(1) << ptr_q) - WIDTH'(1));
    req_hi  = req_in & rr_mask;
    hi_any  = rr_mode & |req_hi;
    winner  = hi_any ? lowest(req_hi) : lowest(req_in);
    cap     = enable & |req_in & (!vld_q | out_ready);
    vld_d   = cap | (vld_q & !out_ready);
    bin_d   = cap ? winner : bin_q;
    oh_d    = cap ? WIDTH'(1) << winner : oh_q;
    ptr_d   = (cap & rr_mode) ? ((winner == OUT_W'(WIDTH - 1)) ? '0 : winner + 1'b1) : ptr_q;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q <= 1'b0;
      bin_q <= '0;
      oh_q  <= '0;
      ptr_q <= '0;
    end else begin
      vld_q <= vld_d;
      bin_q <= bin_d;
      oh_q  <= oh_d;
      ptr_q <= ptr_d;
    end
  end
  assign out_valid  = vld_q;
  assign binary_out = bin_q;
  assign onehot_out = oh_q;
  assign rr_ptr     = ptr_q;
endmodule
